// File: rtl/barrett_seq_ctrl.sv
// Sequencing controller for the radix-16 Barrett iteration datapath: feeds Y digits
// MSB-first, captures the final Z and applies the bounded conditional modulus subtraction.
module barrett_seq_ctrl #(
  parameter int N        = 1024,
  parameter int M        = 4,
  parameter int MAX_CORR = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [N-1:0]   Y,
  input  logic [N-1:0]   M_MOD,
  input  logic [N:0]     Z_IN,
  output logic [M-1:0]   Y_i,
  output logic           CARRY_ADD,
  output logic           CARRY_SUB,
  output logic           DP_RST,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR,
  output logic [N-1:0]   RESULT
);

  localparam int D  = N / M;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(MAX_CORR + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CAPT,
    S_CORR,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    shreg_reg, shreg_next;
  logic [DW-1:0]   dcnt_reg, dcnt_next;
  logic [CW-1:0]   ccnt_reg, ccnt_next;
  logic [N:0]      zr_reg, zr_next;
  logic [M-1:0]    yi_reg, yi_next;
  logic            dp_rst_reg, dp_rst_next;
  logic            csub_reg, csub_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic [N-1:0]    result_reg, result_next;

  logic [N:0]      mod_ext;
  logic            z_ge_m;
  logic [N:0]      z_diff;

  assign mod_ext = {1'b0, M_MOD};
  assign z_ge_m  = (zr_reg >= mod_ext);
  assign z_diff  = zr_reg - mod_ext;

  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    dcnt_next   = dcnt_reg;
    ccnt_next   = ccnt_reg;
    zr_next     = zr_reg;
    err_next    = err_reg;
    result_next = result_reg;
    yi_next     = '0;

    case (state_reg)
      S_IDLE: begin
        if (START) begin
          state_next = S_LOAD;
          shreg_next = Y;
          err_next   = 1'b0;
          ccnt_next  = '0;
        end
      end
      // The digit register is one cycle ahead of the shift register, so the
      // shift starts in LOAD and the last ITER cycle emits nothing new.
      S_LOAD: begin
        state_next = S_ITER;
        dcnt_next  = '0;
        yi_next    = shreg_reg[N-1 -: M];
        shreg_next = shreg_reg << M;
      end
      S_ITER: begin
        dcnt_next = dcnt_reg + DW'(1);
        if (dcnt_reg == DW'(D - 1)) begin
          state_next = S_CAPT;
        end else begin
          yi_next    = shreg_reg[N-1 -: M];
          shreg_next = shreg_reg << M;
        end
      end
      S_CAPT: begin
        zr_next    = Z_IN;
        state_next = S_CORR;
      end
      S_CORR: begin
        if (z_ge_m) begin
          if (ccnt_reg < CW'(MAX_CORR)) begin
            zr_next   = z_diff;
            ccnt_next = ccnt_reg + CW'(1);
          end else begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (state_next == S_DONE && state_reg != S_DONE) begin
      result_next = zr_reg[N-1:0];
    end

    dp_rst_next = (state_next == S_ITER);
    csub_next   = (state_next == S_ITER);
    busy_next   = (state_next != S_IDLE);
    done_next   = (state_next == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= S_IDLE;
      shreg_reg  <= '0;
      dcnt_reg   <= '0;
      ccnt_reg   <= '0;
      zr_reg     <= '0;
      yi_reg     <= '0;
      dp_rst_reg <= 1'b0;
      csub_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      dcnt_reg   <= dcnt_next;
      ccnt_reg   <= ccnt_next;
      zr_reg     <= zr_next;
      yi_reg     <= yi_next;
      dp_rst_reg <= dp_rst_next;
      csub_reg   <= csub_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      result_reg <= result_next;
    end
  end

  assign Y_i       = yi_reg;
  assign CARRY_ADD = 1'b0;
  assign CARRY_SUB = csub_reg;
  assign DP_RST    = dp_rst_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign ERR       = err_reg;
  assign RESULT    = result_reg;

endmodule

// File: tb/tb_barrett_seq_ctrl.sv
// Scoreboard bench for barrett_seq_ctrl with a stubbed datapath (Z_IN held constant).
module tb_barrett_seq_ctrl;

  localparam int N    = 16;
  localparam int M    = 4;
  localparam int D    = N / M;
  localparam int MAXC = 3;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           START = 1'b0;
  logic [N-1:0]   Y = '0;
  logic [N-1:0]   M_MOD = '0;
  logic [N:0]     Z_IN = '0;
  logic [M-1:0]   Y_i;
  logic           CARRY_ADD;
  logic           CARRY_SUB;
  logic           DP_RST;
  logic           BUSY;
  logic           DONE;
  logic           ERR;
  logic [N-1:0]   RESULT;

  barrett_seq_ctrl #(.N(N), .M(M), .MAX_CORR(MAXC)) dut (
    .CLK(CLK), .RST(RST), .START(START), .Y(Y), .M_MOD(M_MOD), .Z_IN(Z_IN),
    .Y_i(Y_i), .CARRY_ADD(CARRY_ADD), .CARRY_SUB(CARRY_SUB), .DP_RST(DP_RST),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] result;
    logic         err;
    int           done_cycle;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Drives one operation; cycle c is the period after the c-th edge following START sampling.
  task automatic run_op(input logic [N-1:0] y_op, input logic [N:0] z_op,
                        input logic [N-1:0] m_op, input bit hold, input bit pulse_mid);
    exp_t         e;
    exp_t         got;
    logic [N:0]   z;
    int           k;
    bit           done_seen;
    bit           iter;
    logic [N-1:0] tmp;
    logic [M-1:0] dig;
    logic [9:0]   act, expv;
    z = z_op;
    k = 0;
    while (z >= {1'b0, m_op} && k < MAXC) begin
      z = z - {1'b0, m_op};
      k++;
    end
    e.err        = (z >= {1'b0, m_op});
    e.result     = z[N-1:0];
    e.done_cycle = D + 4 + k;
    sb_q.push_back(e);

    Y = y_op; Z_IN = z_op; M_MOD = m_op; START = 1'b1;
    @(posedge CLK); #1;
    if (!hold) START = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= D + 4 + MAXC + 2 && !done_seen; c++) begin
      if (c > 1) begin
        @(posedge CLK); #1;
      end
      iter = (c >= 2 && c <= D + 1);
      dig = '0;
      if (iter) begin
        tmp = y_op >> (N - 4 - 4 * (c - 2));
        dig = tmp[M-1:0];
      end
      expv = {dig, iter, iter, 1'b0, 1'b1, (c == e.done_cycle),
              (c == e.done_cycle) ? e.err : 1'b0};
      act  = {Y_i, DP_RST, CARRY_SUB, CARRY_ADD, BUSY, DONE, ERR};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL cycle_outputs c=%0d got {yi,dprst,csub,cadd,busy,done,err}=%b want %b",
                 c, act, expv);
      end
      if (pulse_mid && c == 3) START = 1'b1;
      if (pulse_mid && c == 4) START = 1'b0;
      if (DONE === 1'b1) begin
        done_seen = 1;
        got = sb_q.pop_front();
        vectors++;
        if (RESULT !== got.result || ERR !== got.err || c != got.done_cycle) begin
          miscompares++;
          $display("FAIL done_result got result=%0d err=%b cycle=%0d want result=%0d err=%b cycle=%0d",
                   RESULT, ERR, c, got.result, got.err, got.done_cycle);
        end
        $display("op y=%h z_in=%0d m_mod=%0d -> result=%0d err=%b done_cycle=%0d",
                 y_op, z_op, m_op, RESULT, ERR, c);
      end
    end
    if (!done_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout got no DONE want DONE at cycle %0d", e.done_cycle);
      if (sb_q.size() > 0) got = sb_q.pop_front();
    end
    @(posedge CLK); #1;
    act  = {Y_i, DP_RST, CARRY_SUB, CARRY_ADD, BUSY, DONE, ERR};
    expv = {4'h0, 5'b00000, e.err};
    vectors++;
    if (act !== expv || RESULT !== e.result) begin
      miscompares++;
      $display("FAIL idle_after_done got outs=%b result=%0d want outs=%b result=%0d",
               act, RESULT, expv, e.result);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({Y_i, DP_RST, CARRY_SUB, CARRY_ADD, BUSY, DONE, ERR, RESULT} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got yi=%h dprst=%b csub=%b cadd=%b busy=%b done=%b err=%b result=%h want all zero",
               Y_i, DP_RST, CARRY_SUB, CARRY_ADD, BUSY, DONE, ERR, RESULT);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_digits();
    run_op(16'hA5C3, 17'd42, 16'd100, 0, 0);
  endtask

  task automatic test_correction();
    run_op(16'h1357, 17'd305, 16'd100, 0, 0);
  endtask

  task automatic test_err();
    run_op(16'h0F0F, 17'd401, 16'd100, 0, 0);
  endtask

  task automatic test_wide_z();
    run_op(16'hBEEF, 17'h1000A, 16'd30000, 0, 0);
  endtask

  task automatic test_ignore_start();
    run_op(16'h1234, 17'd205, 16'd100, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_op(16'hFFFF, 17'd150, 16'd100, 1, 0);
    run_op(16'h0001, 17'd7, 16'd100, 0, 0);
  endtask

  task automatic test_reset_mid();
    Y = 16'h5A3C; Z_IN = 17'd333; M_MOD = 16'd100; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    vectors++;
    if (Y_i !== 4'h3 || DP_RST !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_iter got yi=%h dprst=%b want yi=3 dprst=1", Y_i, DP_RST);
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if ({Y_i, DP_RST, CARRY_SUB, CARRY_ADD, BUSY, DONE, ERR, RESULT} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got yi=%h dprst=%b csub=%b busy=%b done=%b err=%b result=%h want all zero",
               Y_i, DP_RST, CARRY_SUB, BUSY, DONE, ERR, RESULT);
    end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    run_op(16'hC0DE, 17'd333, 16'd100, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_digits();
    test_correction();
    test_err();
    test_wide_z();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/barrett_seq_ctrl.md
# barrett_seq_ctrl

Sequencing controller for the radix-16 Barrett modular-multiplication iteration datapath (4-bit Y digit per cycle, Z register updated every clock). It latches the multiplier operand Y and feeds its digits MSB-first to the datapath. It holds the datapath's Z register cleared when idle, captures the final Z, and performs the final conditional subtraction of the modulus to give a fully reduced result. It sits between the top-level operand/command interface and one datapath instance.

## Interface

Parameters:
- N, 1024: operand and modulus width in bits.
- M, 4: digit width in bits. Fixed at 4 to match the datapath digit.
- MAX_CORR, 3: maximum number of final modulus subtractions.

Ports:
- CLK  in  1: clock. All state updates on the rising edge.
- RST  in  1: asynchronous, active-low reset.
- START  in  1: start request. Sampled only in IDLE.
- Y  in  N: multiplier operand. Latched on START acceptance.
- M_MOD  in  N: modulus. Must be held stable by the driver from START until DONE.
- Z_IN  in  N+1: datapath Z register output.
- Y_i  out  M: digit to the datapath.
- CARRY_ADD  out  1: carry-in to the datapath adder.
- CARRY_SUB  out  1: carry-in to the datapath subtractor.
- DP_RST  out  1: active-low clear to the datapath Z register.
- BUSY  out  1: high in every state except IDLE.
- DONE  out  1: one-cycle pulse; RESULT and ERR are valid in that cycle.
- ERR  out  1: correction bound exceeded. Valid with DONE and held until the next START acceptance.
- RESULT  out  N: reduced product. Held until the next START acceptance.

## Operation

- States: IDLE, LOAD, ITER, CAPT, CORR, DONE. D = N/M digits.
- IDLE
  - START=1 → LOAD. Latch Y into the digit shift register, clear ERR, clear the correction counter.
  - START=0 → stay.
- LOAD: one cycle, then → ITER with digit counter = 0.
- ITER: D cycles.
  - Digit counter k = 0..D-1. Y_i = Y[N-1-4k : N-4-4k], MSB digit first.
  - The shift register shifts left by M each cycle.
  - The last digit (k = D-1) → CAPT.
- CAPT: one cycle.
  - Z_IN now holds the final datapath value. Latch Z_IN into the internal N+1-bit register Zr.
  - → CORR.
- CORR: one cycle per step; the correction counter c starts at 0.
  - If Zr ≥ M_MOD (unsigned, N+1-bit compare against the zero-extended modulus) and c < MAX_CORR: Zr ← Zr − M_MOD, c ← c+1, stay.
  - If Zr ≥ M_MOD and c = MAX_CORR: set ERR, → DONE, no subtraction.
  - If Zr < M_MOD: → DONE.
- DONE: one cycle.
  - RESULT ← Zr[N-1:0] (registered on entry, so it is valid during DONE). DONE=1.
  - → IDLE.
- Datapath control:
  - DP_RST=1 only in ITER; 0 in all other states. Z is therefore 0 at the first ITER cycle.
  - CARRY_SUB=1 in ITER, else 0. CARRY_ADD=0 always.
  - Y_i=0 outside ITER.
- START outside IDLE is ignored. No queuing.
- Reset (asynchronous, any state, including mid-ITER or mid-CORR):
  - State → IDLE.
  - Outputs: BUSY=0, DONE=0, ERR=0, RESULT=0, Y_i=0, CARRY_ADD=0, CARRY_SUB=0, DP_RST=0.
  - Internal registers Zr, shift register and counters cleared.

## Timing

- START is sampled high at edge 0. Occupancy after that edge:
  - LOAD: cycle 1.
  - ITER: cycles 2..D+1.
  - CAPT: cycle D+2.
  - CORR: cycles D+3..D+3+k, where k = number of subtractions performed, 0 ≤ k ≤ MAX_CORR.
  - DONE: cycle D+4+k.
- Latency from START to DONE = D+4+k cycles. Minimum D+4; maximum D+4+MAX_CORR.
- BUSY rises in cycle 1 and falls in the cycle after DONE.
- A new START is accepted at the first IDLE cycle after DONE. Back-to-back throughput is D+5+k cycles per operation.
- Outputs are registered. Y_i, DP_RST and CARRY_SUB change only on clock edges, aligned to the datapath capture edge.

## Test plan

- N=16, D=4, Y=16'hA5C3, datapath stubbed → Y_i = A,5,C,3 in cycles 2..5. DP_RST high exactly in cycles 2..5. CARRY_SUB high in the same cycles.
- Stub Z_IN = 3·M_MOD+5 with M_MOD=100 at CAPT → k=3, RESULT=5, ERR=0, DONE at cycle D+7=11.
- Stub Z_IN = 4·M_MOD+1 with M_MOD=100 → 3 subtractions, then ERR=1. RESULT=101, DONE at cycle 11.
- Stub Z_IN=42 with M_MOD=100 → k=0, RESULT=42, DONE at cycle 8.
- Pulse START again during ITER → ignored; digit sequence and DONE timing unchanged. START held high at the IDLE after DONE → the new operation starts.
- Assert RST low in ITER cycle 3 → all outputs go to reset values immediately. After release, START runs a full, correct operation from LOAD.
